// File: rtl/launchpad_mem_sched_if.sv
// Single-port pattern RAM bus between the scheduler (master) and the RAM (slave).
interface launchpad_mem_sched_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 4
);
    logic              ce;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    modport master (output ce, rw, addr, wdata, input  rdata);
    modport slave  (input  ce, rw, addr, wdata, output rdata);
endinterface

// File: rtl/launchpad_mem_sched.sv
// Serialises key-record writes and playback-tick reads onto one RAM port.
// Define LAUNCHPAD_KEY_FIFO_EN to replace the single key slot with a 4-entry FIFO.
module launchpad_mem_sched #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [1:0]            mode_i,
    input  logic                  key_vld_i,
    input  logic [DATA_W-1:0]     key_code_i,
    input  logic                  play_tick_i,
    input  logic                  clr_i,
    launchpad_mem_sched_if.master ram,
    output logic                  play_vld_o,
    output logic [DATA_W-1:0]     play_code_o,
    output logic [ADDR_W-1:0]     len_o,
    output logic                  busy_o,
    output logic                  full_o,
    output logic                  drop_o
);
`ifdef LAUNCHPAD_KEY_FIFO_EN
    localparam int KQ_DEPTH = 4;
`else
    localparam int KQ_DEPTH = 1;
`endif
    localparam logic [ADDR_W-1:0] LEN_MAX = {ADDR_W{1'b1}};

    typedef enum logic [2:0] {IDLE, WR_SETUP, WR_STROBE, RD_SETUP, RD_STROBE, RD_CAP} state_t;
    state_t state_q, state_d;

    logic                          ce_q, ce_d, rw_q, rw_d;
    logic [ADDR_W-1:0]             addr_q, addr_d, len_q, len_d, rptr_q, rptr_d;
    logic [DATA_W-1:0]             wdata_q, wdata_d, play_code_q, play_code_d;
    logic                          play_vld_q, play_vld_d, drop_q, drop_d;
    logic                          tick_q, tick_d, clr_pend_q, clr_pend_d;
    logic                          rr_wr_q, rr_wr_d;  // last contended grant went to the write side
    logic [1:0]                    mode_q;
    logic [3:0][DATA_W-1:0]        kq_q, kq_d;
    logic [1:0]                    kwp_q, kwp_d, krp_q, krp_d;
    logic [2:0]                    kcnt_q, kcnt_d;

    function automatic logic [1:0] kq_next(input logic [1:0] p);
        return (p == 2'(KQ_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    logic idle, clr_take, clr_blk, key_en, key_room, key_acc, key_drop;
    logic tick_en, tick_acc, tick_drop, kp, tp;
    logic [DATA_W-1:0] head;

    assign idle      = (state_q == IDLE);
    assign clr_take  = idle && (clr_i || clr_pend_q);
    assign clr_blk   = clr_i || clr_take;
    assign key_en    = key_vld_i && mode_i[0] && !clr_blk;
    // Queued keys count against capacity so an accepted key always gets a RAM slot.
    assign key_room  = (kcnt_q != 3'(KQ_DEPTH)) &&
                       (({1'b0, len_q} + (ADDR_W+1)'(kcnt_q)) < {1'b0, LEN_MAX});
    assign key_acc   = key_en && key_room;
    assign key_drop  = key_en && !key_room;
    assign tick_en   = play_tick_i && mode_i[1] && (len_q != '0) && !clr_blk;
    assign tick_acc  = tick_en && !tick_q;
    assign tick_drop = tick_en && tick_q;
    assign kp        = key_acc || (mode_i[0] && kcnt_q != 3'd0);
    assign tp        = tick_acc || (mode_i[1] && tick_q);
    assign head      = (kcnt_q != 3'd0) ? kq_q[krp_q] : key_code_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;      ce_q <= 1'b0;        rw_q <= 1'b1;
            addr_q <= '0;         wdata_q <= '0;       play_vld_q <= 1'b0;
            play_code_q <= '0;    len_q <= '0;         rptr_q <= '0;
            drop_q <= 1'b0;       tick_q <= 1'b0;      clr_pend_q <= 1'b0;
            rr_wr_q <= 1'b0;      mode_q <= 2'b00;     kq_q <= '0;
            kwp_q <= 2'd0;        krp_q <= 2'd0;       kcnt_q <= 3'd0;
        end else begin
            state_q <= state_d;   ce_q <= ce_d;        rw_q <= rw_d;
            addr_q <= addr_d;     wdata_q <= wdata_d;  play_vld_q <= play_vld_d;
            play_code_q <= play_code_d; len_q <= len_d; rptr_q <= rptr_d;
            drop_q <= drop_d;     tick_q <= tick_d;    clr_pend_q <= clr_pend_d;
            rr_wr_q <= rr_wr_d;   mode_q <= mode_i;    kq_q <= kq_d;
            kwp_q <= kwp_d;       krp_q <= krp_d;      kcnt_q <= kcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;   ce_d = ce_q;          rw_d = rw_q;
        addr_d = addr_q;     wdata_d = wdata_q;    play_vld_d = 1'b0;
        play_code_d = play_code_q; len_d = len_q;  rptr_d = rptr_q;
        drop_d = drop_q;     tick_d = tick_q;      clr_pend_d = clr_pend_q;
        rr_wr_d = rr_wr_q;   kq_d = kq_q;          kwp_d = kwp_q;
        krp_d = krp_q;       kcnt_d = kcnt_q;

        if (key_acc) begin
            kq_d[kwp_q] = key_code_i;
            kwp_d       = kq_next(kwp_q);
            kcnt_d      = kcnt_q + 3'd1;
        end
        if (tick_acc) tick_d = 1'b1;
        if (key_drop || tick_drop) drop_d = 1'b1;
        if (clr_i && !idle) clr_pend_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (clr_take) begin
                    len_d = '0;  rptr_d = '0;  drop_d = 1'b0;  tick_d = 1'b0;
                    kcnt_d = 3'd0;  kwp_d = 2'd0;  krp_d = 2'd0;  clr_pend_d = 1'b0;
                end else begin
                    if (!mode_i[0]) begin
                        kcnt_d = 3'd0;  kwp_d = 2'd0;  krp_d = 2'd0;
                    end
                    if (!mode_i[1]) tick_d = 1'b0;
                    // The round-robin flag only moves on contention, so an uncontested
                    // grant never steals the other side's turn.
                    if (kp && (!tp || !rr_wr_q)) begin
                        state_d = WR_SETUP;
                        ce_d = 1'b1;  rw_d = 1'b0;  addr_d = len_q;  wdata_d = head;
                        if (tp) rr_wr_d = 1'b1;
                    end else if (tp) begin
                        state_d = RD_SETUP;
                        ce_d = 1'b1;  rw_d = 1'b1;  addr_d = rptr_q;
                        if (kp) rr_wr_d = 1'b0;
                    end
                end
            end
            WR_SETUP:  state_d = WR_STROBE;
            WR_STROBE: begin
                state_d = IDLE;
                ce_d = 1'b0;  rw_d = 1'b1;
                len_d  = len_q + ADDR_W'(1);
                kcnt_d = kcnt_d - 3'd1;
                krp_d  = kq_next(krp_q);
            end
            RD_SETUP:  state_d = RD_STROBE;
            RD_STROBE: begin
                state_d = RD_CAP;
                ce_d = 1'b0;  rw_d = 1'b1;
                play_vld_d  = 1'b1;
                play_code_d = ram.rdata;
            end
            RD_CAP: begin
                state_d = IDLE;
                tick_d  = 1'b0;
                rptr_d  = (rptr_q + ADDR_W'(1) == len_q) ? '0 : rptr_q + ADDR_W'(1);
            end
            default: state_d = IDLE;
        endcase

        // Entering a play mode restarts the loop from the first recorded entry.
        if (mode_i[1] && (mode_i != mode_q)) rptr_d = '0;
    end

    assign ram.ce      = ce_q;
    assign ram.rw      = rw_q;
    assign ram.addr    = addr_q;
    assign ram.wdata   = wdata_q;
    assign play_vld_o  = play_vld_q;
    assign play_code_o = play_code_q;
    assign len_o       = len_q;
    assign busy_o      = (state_q != IDLE);
    assign full_o      = (len_q == LEN_MAX);
    assign drop_o      = drop_q;
endmodule

// File: tb/tb_launchpad_mem_sched.sv
// Bench for launchpad_mem_sched: RAM model on the bus, recorded-pattern queue as reference.
module tb_launchpad_mem_sched;
  logic clk = 1'b0, rst_n;
  logic [1:0] mode;
  logic key_vld, play_tick, clr;
  logic [3:0] key_code, play_code;
  logic play_vld, busy, full, drop;
  logic [11:0] len;
  int n_cmp, n_fail, ce_cycles, pptr;
  logic [3:0] rec[$];
  logic [3:0] mem [4096];

  always #5 clk = ~clk;

  launchpad_mem_sched_if #(.ADDR_W(12), .DATA_W(4)) ram_if ();

  launchpad_mem_sched #(.ADDR_W(12), .DATA_W(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .key_vld_i(key_vld), .key_code_i(key_code),
    .play_tick_i(play_tick), .clr_i(clr), .ram(ram_if.master), .play_vld_o(play_vld),
    .play_code_o(play_code), .len_o(len), .busy_o(busy), .full_o(full), .drop_o(drop));

  always @(posedge clk) if (ram_if.ce && !ram_if.rw) mem[ram_if.addr] <= ram_if.wdata;
  assign ram_if.rdata = (ram_if.ce && ram_if.rw) ? mem[ram_if.addr] : 4'h0;
  always @(posedge clk) if (ram_if.ce) ce_cycles <= ce_cycles + 1;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_key(input logic [3:0] c);
    key_vld = 1'b1; key_code = c; @(negedge clk); key_vld = 1'b0;
  endtask

  task automatic pulse_tick();
    play_tick = 1'b1; @(negedge clk); play_tick = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    rec.delete(); pptr = 0;
  endtask

  task automatic test_reset();
    logic [37:0] got, exp;
    exp = {1'b0, 1'b1, 12'h0, 4'h0, 1'b0, 4'h0, 12'h0, 3'b000};
    step(2);
    got = {ram_if.ce, ram_if.rw, ram_if.addr, ram_if.wdata, play_vld, play_code, len, busy, full, drop};
    n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL reset_held: got %h want %h", got, exp); end
    rst_n = 1'b1; step(2);
    got = {ram_if.ce, ram_if.rw, ram_if.addr, ram_if.wdata, play_vld, play_code, len, busy, full, drop};
    n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL reset_idle: got %h want %h", got, exp); end
  endtask

  task automatic test_record();
    logic [3:0] codes [3] = '{4'd1, 4'd6, 4'd3};
    logic [17:0] got, exp;
    mode = 2'b01; step(1);
    foreach (codes[i]) begin
      exp = {1'b1, 1'b0, 12'(rec.size()), codes[i]};
      pulse_key(codes[i]);
      got = {ram_if.ce, ram_if.rw, ram_if.addr, ram_if.wdata};
      n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL rec_setup%0d: got %h want %h", i, got, exp); end
      step(1);
      got = {ram_if.ce, ram_if.rw, ram_if.addr, ram_if.wdata};
      n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL rec_strobe%0d: got %h want %h", i, got, exp); end
      rec.push_back(codes[i]);
      step(1);
      n_cmp++;
      if ({ram_if.ce, len} !== {1'b0, 12'(rec.size())}) begin
        n_fail++; $display("FAIL rec_len%0d: got ce=%b len=%0d want ce=0 len=%0d", i, ram_if.ce, len, rec.size());
      end
      step(2);
    end
    n_cmp++; if (drop !== 1'b0) begin n_fail++; $display("FAIL rec_drop: got %b want 0", drop); end
  endtask

  task automatic test_play(input int ticks);
    mode = 2'b10; step(1); pptr = 0;
    for (int i = 0; i < ticks; i++) begin
      pulse_tick();
      n_cmp++;
      if ({ram_if.ce, ram_if.rw, ram_if.addr} !== {2'b11, 12'(pptr)}) begin
        n_fail++; $display("FAIL play_setup%0d: got ce=%b rw=%b addr=%0d want 1 1 %0d", i, ram_if.ce, ram_if.rw, ram_if.addr, pptr);
      end
      step(2);
      n_cmp++;
      if ({play_vld, play_code} !== {1'b1, rec[pptr]}) begin
        n_fail++; $display("FAIL play_code%0d: got vld=%b code=%h want 1 %h", i, play_vld, play_code, rec[pptr]);
      end
      pptr = (pptr + 1) % rec.size();
      step(1);
      n_cmp++; if (play_vld !== 1'b0) begin n_fail++; $display("FAIL play_pulse%0d: got %b want 0", i, play_vld); end
      step(2);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] c;
    mode = 2'b01; step(1); pulse_clr();
    for (int i = 0; i < 2; i++) begin
      c = 4'($urandom); pulse_key(c); rec.push_back(c); step(3);
    end
    mode = 2'b11; step(1); pptr = 0;
    // Contention 1: write wins first
    c = 4'($urandom); play_tick = 1'b1; pulse_key(c); play_tick = 1'b0;
    n_cmp++;
    if ({ram_if.ce, ram_if.rw, ram_if.addr, ram_if.wdata} !== {2'b10, 12'(rec.size()), c}) begin
      n_fail++; $display("FAIL rr1_write: got rw=%b addr=%0d wdata=%h want 0 %0d %h", ram_if.rw, ram_if.addr, ram_if.wdata, rec.size(), c);
    end
    rec.push_back(c);
    step(5);
    n_cmp++;
    if ({play_vld, play_code} !== {1'b1, rec[pptr]}) begin
      n_fail++; $display("FAIL rr1_read: got vld=%b code=%h want 1 %h", play_vld, play_code, rec[pptr]);
    end
    pptr = (pptr + 1) % rec.size();
    step(2);
    // Contention 2: read wins this time
    c = 4'($urandom); play_tick = 1'b1; pulse_key(c); play_tick = 1'b0;
    n_cmp++;
    if ({ram_if.ce, ram_if.rw, ram_if.addr} !== {2'b11, 12'(pptr)}) begin
      n_fail++; $display("FAIL rr2_read_first: got ce=%b rw=%b addr=%0d want 1 1 %0d", ram_if.ce, ram_if.rw, ram_if.addr, pptr);
    end
    step(2);
    n_cmp++;
    if ({play_vld, play_code} !== {1'b1, rec[pptr]}) begin
      n_fail++; $display("FAIL rr2_read: got vld=%b code=%h want 1 %h", play_vld, play_code, rec[pptr]);
    end
    pptr = (pptr + 1) % rec.size();
    step(2);
    n_cmp++;
    if ({ram_if.ce, ram_if.rw, ram_if.addr, ram_if.wdata} !== {2'b10, 12'(rec.size()), c}) begin
      n_fail++; $display("FAIL rr2_write: got ce=%b rw=%b addr=%0d wdata=%h want 1 0 %0d %h", ram_if.ce, ram_if.rw, ram_if.addr, ram_if.wdata, rec.size(), c);
    end
    rec.push_back(c);
    step(2);
    n_cmp++; if (len !== 12'(rec.size())) begin n_fail++; $display("FAIL rr2_len: got %0d want %0d", len, rec.size()); end
  endtask

  task automatic test_drop();
    int ce0;
    mode = 2'b01; step(1); pulse_clr();
    key_vld = 1'b1; key_code = 4'h5; @(negedge clk);
    key_code = 4'h9; @(negedge clk); key_vld = 1'b0;
    step(1);
    n_cmp++;
    if ({len, drop} !== {12'd1, 1'b1}) begin n_fail++; $display("FAIL drop_second: got len=%0d drop=%b want 1 1", len, drop); end
    step(1);
    n_cmp++; if ({ram_if.ce, busy} !== 2'b00) begin n_fail++; $display("FAIL drop_nowrite: got ce=%b busy=%b want 0 0", ram_if.ce, busy); end
    pulse_clr();
    n_cmp++;
    if ({len, drop} !== {12'd0, 1'b0}) begin n_fail++; $display("FAIL clr: got len=%0d drop=%b want 0 0", len, drop); end
    ce0 = ce_cycles;
    clr = 1'b1; pulse_key(4'hA); clr = 1'b0;
    step(3);
    n_cmp++;
    if ({len, drop, 32'(ce_cycles)} !== {12'd0, 1'b0, 32'(ce0)}) begin
      n_fail++; $display("FAIL clr_key: got len=%0d drop=%b ce_cycles=%0d want 0 0 %0d", len, drop, ce_cycles, ce0);
    end
    mode = 2'b10; step(1);
    pulse_tick(); step(2);
    n_cmp++;
    if ({play_vld, drop, 32'(ce_cycles)} !== {1'b0, 1'b0, 32'(ce0)}) begin
      n_fail++; $display("FAIL tick_len0: got vld=%b drop=%b ce_cycles=%0d want 0 0 %0d", play_vld, drop, ce_cycles, ce0);
    end
  endtask

  task automatic test_random(input int rounds);
    logic [3:0] c;
    for (int r = 0; r < rounds; r++) begin
      mode = 2'b01; step(1); pulse_clr();
      for (int i = 0; i < int'($urandom_range(3, 10)); i++) begin
        c = 4'($urandom);
        pulse_key(c);
        n_cmp++;
        if ({ram_if.ce, ram_if.rw, ram_if.addr, ram_if.wdata} !== {2'b10, 12'(rec.size()), c}) begin
          n_fail++; $display("FAIL rnd_write r%0d k%0d: got addr=%0d wdata=%h want %0d %h", r, i, ram_if.addr, ram_if.wdata, rec.size(), c);
        end
        rec.push_back(c);
        step(2 + int'($urandom_range(0, 3)));
      end
      test_play(int'($urandom_range(4, 15)));
      n_cmp++; if (drop !== 1'b0) begin n_fail++; $display("FAIL rnd_drop r%0d: got %b want 0", r, drop); end
    end
  endtask

  task automatic test_full();
    logic [3:0] c;
    int ce0;
    mode = 2'b01; step(1); pulse_clr();
    for (int i = 0; i < 4095; i++) begin
      if (i == 4094) begin
        n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL full_early: got %b want 0 at len %0d", full, len); end
      end
      c = 4'($urandom);
      pulse_key(c);
      n_cmp++;
      if ({ram_if.ce, ram_if.rw, ram_if.addr} !== {2'b10, 12'(i)}) begin
        n_fail++; $display("FAIL full_fill%0d: got ce=%b rw=%b addr=%0d want 1 0 %0d", i, ram_if.ce, ram_if.rw, ram_if.addr, i);
      end
      rec.push_back(c);
      step(2);
    end
    n_cmp++;
    if ({len, full, drop} !== {12'd4095, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL full_set: got len=%0d full=%b drop=%b want 4095 1 0", len, full, drop);
    end
    ce0 = ce_cycles;
    pulse_key(4'hF); step(3);
    n_cmp++;
    if ({32'(ce_cycles), drop, len} !== {32'(ce0), 1'b1, 12'd4095}) begin
      n_fail++; $display("FAIL full_drop: got ce_cycles=%0d drop=%b len=%0d want %0d 1 4095", ce_cycles, drop, len, ce0);
    end
    mode = 2'b10; step(1);
    pulse_tick(); step(2);
    n_cmp++;
    if ({play_vld, play_code} !== {1'b1, rec[0]}) begin
      n_fail++; $display("FAIL full_readback: got vld=%b code=%h want 1 %h", play_vld, play_code, rec[0]);
    end
    step(3);
  endtask

  task automatic test_reset_mid_access();
    logic [37:0] got, exp;
    int ce0;
    exp = {1'b0, 1'b1, 12'h0, 4'h0, 1'b0, 4'h0, 12'h0, 3'b000};
    mode = 2'b01; step(1); pulse_clr();
    pulse_key(4'h7); step(1);
    n_cmp++; if ({ram_if.ce, ram_if.rw, busy} !== 3'b101) begin n_fail++; $display("FAIL mid_strobe: got ce=%b rw=%b busy=%b want 1 0 1", ram_if.ce, ram_if.rw, busy); end
    rst_n = 1'b0; #1;
    got = {ram_if.ce, ram_if.rw, ram_if.addr, ram_if.wdata, play_vld, play_code, len, busy, full, drop};
    n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL mid_reset: got %h want %h", got, exp); end
    @(negedge clk); rst_n = 1'b1;
    ce0 = ce_cycles; step(5);
    n_cmp++;
    if ({32'(ce_cycles), len} !== {32'(ce0), 12'd0}) begin
      n_fail++; $display("FAIL mid_after: got ce_cycles=%0d len=%0d want %0d 0", ce_cycles, len, ce0);
    end
  endtask

  initial begin
    rst_n = 1'b0; mode = 2'b00; key_vld = 1'b0; key_code = 4'h0;
    play_tick = 1'b0; clr = 1'b0; n_cmp = 0; n_fail = 0; ce_cycles = 0; pptr = 0;
    test_reset();
    test_record();
    test_play(4);
    test_round_robin();
    test_drop();
    test_random(3);
    test_full();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/launchpad_mem_sched.md
# launchpad_mem_sched

Memory access scheduler between the LaunchPad key/playback logic and the single-port 4-bit pattern RAM. It serialises key-record writes and playback-tick reads onto one port (CE/RW/ADDR/WDATA), arbitrates round-robin when both are pending, and tracks recorded length and the loop read pointer. It sits between the keypad encoder/DIP-mode decode and the RAM, and drives the playback output stage.

## Interface
- ADDR_W, 12, RAM address width; usable depth 2^ADDR_W-1 entries
- DATA_W, 4, key code / RAM data width
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-low reset
- MODE  in  2  00 idle, 01 record, 10 play, 11 play+record
- KEY_VLD  in  1  one-cycle pulse, key event
- KEY_CODE  in  DATA_W  key code, valid with KEY_VLD
- PLAY_TICK  in  1  one-cycle playback rate strobe
- CLR  in  1  one-cycle pulse, erase recording
- RDATA  in  DATA_W  RAM read data, valid at end of strobe cycle
- CE  out  1  RAM chip enable
- RW  out  1  1 = read, 0 = write
- ADDR  out  ADDR_W  RAM address
- WDATA  out  DATA_W  RAM write data
- PLAY_VLD  out  1  one-cycle pulse, PLAY_CODE valid
- PLAY_CODE  out  DATA_W  code read back
- LEN  out  ADDR_W  recorded entry count
- BUSY  out  1  access in progress (state ≠ IDLE)
- FULL  out  1  LEN == 2^ADDR_W-1
- DROP  out  1  sticky: a key or tick was discarded; cleared by CLR or reset

## Operation
- States: IDLE, WR_SETUP, WR_STROBE, RD_SETUP, RD_STROBE, RD_CAP.
- Requests latch into pending slots: key slot (code) accepted when MODE[0]=1; tick flag set when MODE[1]=1 and LEN≠0. Key arriving with key slot occupied or FULL=1: dropped, DROP=1. Tick arriving with tick flag set: dropped, DROP=1. Tick with LEN=0: ignored silently.
- IDLE arbitration: only key pending → WR_SETUP; only tick → RD_SETUP; both → requester not served last (round-robin flag, reset value favours write).
- WR_SETUP→WR_STROBE→IDLE: ADDR=LEN, WDATA=code, RW=0, CE=1 both cycles; LEN increments leaving WR_STROBE; key slot freed.
- RD_SETUP→RD_STROBE→RD_CAP→IDLE: ADDR=rptr, RW=1, CE=1 in SETUP/STROBE; RDATA registered at end of STROBE; RD_CAP drives PLAY_VLD=1 with PLAY_CODE; rptr increments, wraps to 0 when rptr+1 == LEN.
- rptr reset to 0 on any MODE transition into 10 or 11.
- MODE change mid-access: current access completes; pending slot of a now-disabled requester is cleared at next IDLE.
- CLR: taken only in IDLE (held pending while BUSY); sets LEN=0, rptr=0, DROP=0, clears both slots. CLR and KEY_VLD same cycle: CLR wins, key discarded (no DROP).
- Reset (any time, incl. mid-access): CE=0, RW=1, ADDR=0, WDATA=0, PLAY_VLD=0, PLAY_CODE=0, LEN=0, BUSY=0, FULL=0, DROP=0, slots empty, state IDLE.

## Timing
- CE/RW/ADDR/WDATA registered; stable for whole SETUP+STROBE pair; CE=0, RW=1 in IDLE.
- Write: KEY_VLD at cycle n → WR_SETUP n+1 (if idle) → LEN updated visible n+3.
- Read: PLAY_TICK at n → PLAY_VLD at n+3 (if idle, no contention).
- Back-to-back accesses: IDLE cycle between each; max one access per 3 (write) / 4 (read) cycles.
- FULL combinational from LEN register.

## Configuration
- LAUNCHPAD_KEY_FIFO_EN defined: key slot is a 4-entry FIFO; key dropped only when FIFO full or FULL accounting (LEN + FIFO occupancy) reaches depth; CLR flushes FIFO.
- Undefined: single-entry key holding register as described above.

## Test plan
- Reset low mid-WR_STROBE → all outputs at reset values next edge, LEN=0, no further CE.
- MODE=01, keys 1,6,3 spaced 5 cycles → three writes ADDR 0,1,2 WDATA 1,6,3, LEN=3, DROP=0.
- MODE=10, LEN=3, 4 ticks spaced 6 cycles → PLAY_CODE 1,6,3,1 (wrap), each 3 cycles after tick.
- MODE=11, KEY_VLD and PLAY_TICK same cycle twice → first write then read, then read then write (round-robin).
- Two KEY_VLD in consecutive cycles (FIFO off) → first written, second dropped, DROP=1; CLR → LEN=0, DROP=0.
- Fill LEN to 4095 (ADDR_W=12) → FULL=1, next key dropped, DROP=1, no write cycle.
